// File: rtl/uart_rx_seqcheck_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_seqcheck_if : serial line and status bundle of the receiver  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface uart_rx_seqcheck_if;
   logic        rx_in;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        seq_err;
   logic        locked;
   logic [15:0] char_count;
   logic [15:0] err_count;

   modport master (
      input  rx_in,
      output rx_data, rx_valid, frame_err, seq_err, locked, char_count, err_count
   );

   modport slave (
      output rx_in,
      input  rx_data, rx_valid, frame_err, seq_err, locked, char_count, err_count
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_seqcheck.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_seqcheck : 8N1 UART receiver (16x oversampling) with ASCII  |
// | successor checker, built when UART_RX_SEQCHK_EN is defined.          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_rx_seqcheck #(
   parameter int DIV = 163
) (
   input  wire logic             sysclk,
   input  wire logic             reset,
   uart_rx_seqcheck_if.master    bus
);

   localparam int               c_tick_w  = $clog2(DIV);
   localparam logic [c_tick_w-1:0] c_reload = c_tick_w'(DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic                r_sync1;
   logic                r_sync2;
   logic                w_rxs;
   logic [c_tick_w-1:0] r_tick_cnt;
   logic                w_tick;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_sc;
   logic [3:0]          w_sc_nxt;
   logic [2:0]          r_bc;
   logic [2:0]          w_bc_nxt;
   logic [7:0]          r_sr;
   logic [7:0]          w_sr_nxt;
   logic                w_good;
   logic                w_ferr;
   logic                w_err_evt;

   logic [7:0]          r_rx_data;
   logic                r_rx_valid;
   logic                r_frame_err;
   logic [15:0]         r_char_count;
   logic [15:0]         r_err_count;

   // Idle-high reset value keeps a held-low line from looking like a start bit
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rx_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_tick_cnt <= c_reload;
      end else if (r_tick_cnt == '0) begin
         r_tick_cnt <= c_reload;
      end else begin
         r_tick_cnt <= r_tick_cnt - 1'b1;
      end
   end

   assign w_tick = (r_tick_cnt == '0);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sc    <= 4'd0;
         r_bc    <= 3'd0;
         r_sr    <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_sc    <= w_sc_nxt;
         r_bc    <= w_bc_nxt;
         r_sr    <= w_sr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sc_nxt    = r_sc;
      w_bc_nxt    = r_bc;
      w_sr_nxt    = r_sr;
      w_good      = 1'b0;
      w_ferr      = 1'b0;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_rxs) begin
                  w_sc_nxt    = 4'd0;
                  w_state_nxt = ST_START;
               end
            end
            // Eight ticks in, the start bit is re-checked at its centre
            ST_START: begin
               if (r_sc == 4'd7) begin
                  if (!w_rxs) begin
                     w_sc_nxt    = 4'd0;
                     w_bc_nxt    = 3'd0;
                     w_state_nxt = ST_DATA;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_sc_nxt = r_sc + 4'd1;
               end
            end
            ST_DATA: begin
               w_sc_nxt = r_sc + 4'd1;
               if (r_sc == 4'd15) begin
                  w_sr_nxt = {w_rxs, r_sr[7:1]};
                  w_bc_nxt = r_bc + 3'd1;
                  if (r_bc == 3'd7) begin
                     w_state_nxt = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               w_sc_nxt = r_sc + 4'd1;
               if (r_sc == 4'd15) begin
                  if (w_rxs) begin
                     w_good      = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_ferr      = 1'b1;
                     w_state_nxt = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (w_rxs) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

`ifdef UART_RX_SEQCHK_EN
   logic [7:0] r_prev;
   logic       r_locked;
   logic       r_seq_err;
   logic [7:0] w_exp;
   logic       w_seq_bad;

   assign w_exp     = (r_prev == 8'h7F) ? 8'h20 : (r_prev + 8'd1);
   assign w_seq_bad = w_good & r_locked & (r_sr != w_exp);
   assign w_err_evt = w_ferr | w_seq_bad;

   // Every good character becomes the new reference, so one error never cascades
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_prev    <= 8'h00;
         r_locked  <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         r_seq_err <= w_seq_bad;
         if (w_good) begin
            r_prev   <= r_sr;
            r_locked <= 1'b1;
         end else if (w_ferr) begin
            r_locked <= 1'b0;
         end
      end
   end

   assign bus.seq_err = r_seq_err;
   assign bus.locked  = r_locked;
`else
   assign w_err_evt   = w_ferr;
   assign bus.seq_err = 1'b0;
   assign bus.locked  = 1'b0;
`endif

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_char_count <= 16'd0;
         r_err_count  <= 16'd0;
      end else begin
         r_rx_valid  <= w_good;
         r_frame_err <= w_ferr;
         if (w_good) begin
            r_rx_data    <= r_sr;
            r_char_count <= r_char_count + 16'd1;
         end
         if (w_err_evt && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign bus.rx_data    = r_rx_data;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.frame_err  = r_frame_err;
   assign bus.char_count = r_char_count;
   assign bus.err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_seqcheck.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_seqcheck : directed bench with expected-character queue   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_uart_rx_seqcheck;

   localparam int c_div = 4;
   localparam int c_bit = 16 * c_div;
`ifdef UART_RX_SEQCHK_EN
   localparam bit c_seq_en = 1'b1;
`else
   localparam bit c_seq_en = 1'b0;
`endif

   typedef struct {
      logic [7:0] d;
      logic       s;
   } exp_t;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;
   uart_rx_seqcheck_if bus ();

   uart_rx_seqcheck #(.DIV(c_div)) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus.master)
   );

   always #5 sysclk = ~sysclk;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];

   logic [7:0] m_prev;
   logic [7:0] m_last;
   bit         m_locked;
   int         m_chars;
   int         m_errs;
   int         m_valids = 0;
   int         m_ferrs  = 0;
   int         m_seqs   = 0;
   int         n_valid  = 0;
   int         n_ferr   = 0;
   int         n_seq    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge sysclk) begin
      if (bus.frame_err === 1'b1) n_ferr++;
      if (bus.seq_err === 1'b1) n_seq++;
      if (bus.rx_valid === 1'b1) begin
         n_valid++;
         if (q.size() == 0) begin
            chk("unexpected_valid", q.size(), 1);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rx_data", bus.rx_data, e.d);
            chk("seq_err", bus.seq_err, e.s);
         end
      end
   end

   task automatic model_reset();
      m_prev   = 8'h00;
      m_last   = 8'h00;
      m_locked = 1'b0;
      m_chars  = 0;
      m_errs   = 0;
   endtask

   task automatic model_good(input logic [7:0] c);
      exp_t       e;
      logic [7:0] ex;
      ex  = (m_prev == 8'h7F) ? 8'h20 : (m_prev + 8'd1);
      e.d = c;
      e.s = c_seq_en && m_locked && (c != ex);
      if (e.s) begin
         m_errs++;
         m_seqs++;
      end
      m_prev   = c;
      m_locked = c_seq_en;
      m_last   = c;
      m_chars++;
      m_valids++;
      q.push_back(e);
   endtask

   task automatic drive_bit(input logic b);
      bus.rx_in = b;
      repeat (c_bit) @(negedge sysclk);
   endtask

   task automatic send_char(input logic [7:0] c, input logic stop);
      if (stop) begin
         model_good(c);
      end else begin
         m_errs++;
         m_ferrs++;
         m_locked = 1'b0;
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(c[i]);
      drive_bit(stop);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge sysclk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_rx_data"}, bus.rx_data, m_last);
      chk({tag, "_locked"}, bus.locked, m_locked);
      chk({tag, "_char_count"}, bus.char_count, m_chars);
      chk({tag, "_err_count"}, bus.err_count, m_errs);
      chk({tag, "_valid_total"}, n_valid, m_valids);
      chk({tag, "_ferr_total"}, n_ferr, m_ferrs);
      chk({tag, "_seq_total"}, n_seq, m_seqs);
      chk({tag, "_pending"}, q.size(), 0);
   endtask

   initial begin
      bus.rx_in = 1'b1;
      model_reset();
      repeat (5) @(negedge sysclk);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_seq_err", bus.seq_err, 0);
      check_outputs("rst");
      reset = 1'b0;
      repeat (2) drive_bit(1'b1);

      // Single character locks the checker
      send_char(8'h41, 1'b1);
      repeat (2) drive_bit(1'b1);
      check_outputs("single");

      // Wrap from 0x7F to 0x20, back-to-back frames
      do_reset();
      send_char(8'h7E, 1'b1);
      send_char(8'h7F, 1'b1);
      send_char(8'h20, 1'b1);
      send_char(8'h21, 1'b1);
      repeat (2) drive_bit(1'b1);
      check_outputs("wrap");

      // Skipped character, then resync on the offender
      do_reset();
      send_char(8'h30, 1'b1);
      send_char(8'h32, 1'b1);
      repeat (2) drive_bit(1'b1);
      check_outputs("skip");
      send_char(8'h33, 1'b1);
      repeat (2) drive_bit(1'b1);
      check_outputs("resync");

      // Framing error followed by a held break
      send_char(8'h55, 1'b0);
      repeat (3) drive_bit(1'b0);
      repeat (3) drive_bit(1'b1);
      check_outputs("break");
      send_char(8'h60, 1'b1);
      repeat (2) drive_bit(1'b1);
      check_outputs("after_break");

      // Short low glitch on an idle line
      bus.rx_in = 1'b0;
      repeat (20) @(negedge sysclk);
      bus.rx_in = 1'b1;
      repeat (3) drive_bit(1'b1);
      check_outputs("glitch");

      // Reset in the middle of 0xA5, then reset held with the line toggling
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      reset     = 1'b1;
      bus.rx_in = 1'b1;
      model_reset();
      repeat (2) @(negedge sysclk);
      check_outputs("midreset");
      for (int i = 0; i < 200; i++) begin
         bus.rx_in = i[2];
         @(negedge sysclk);
      end
      bus.rx_in = 1'b1;
      chk("held_rx_valid", bus.rx_valid, 0);
      check_outputs("held");
      repeat (4) @(negedge sysclk);
      reset = 1'b0;
      repeat (4) drive_bit(1'b1);
      check_outputs("released");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
